// File: rtl/icache_controller_if.sv
// CPU-fetch and instruction-memory signal bundle for icache_controller.
// The slave modport is the cache's view; master is the CPU/memory side.
interface icache_controller_if #(
  parameter int ADDR_BITS = 10
);
  logic [31:0]          PC;
  logic [31:0]          INSTRUCTION;
  logic                 BUSYWAIT;
  logic                 MEM_READ;
  logic [ADDR_BITS-5:0] MEM_ADDRESS;
  logic [127:0]         MEM_READDATA;
  logic                 MEM_BUSYWAIT;

  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache: hits served combinationally, misses refill a 16-byte block.
// Optional macro ICACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module icache_controller #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_BITS  = 10
) (
  input  logic CLK,
  input  logic RESET,
  icache_controller_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int BLK_W = ADDR_BITS - 4;
  localparam int TAG_W = BLK_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_BLOCKS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [NUM_BLOCKS];
  logic [TAG_W-1:0]       tag_d  [NUM_BLOCKS];
  logic [127:0]           data_q [NUM_BLOCKS];
  logic [127:0]           data_d [NUM_BLOCKS];
  logic [BLK_W-1:0]       miss_addr_q, miss_addr_d;
  logic [127:0]           fill_data_q, fill_data_d;
  logic                   mem_read_q, mem_read_d;

  logic [1:0]             offset;
  logic [IDX_W-1:0]       index;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic                   pc_unused;

  assign offset    = bus.PC[3:2];
  assign index     = bus.PC[3+IDX_W:4];
  assign tag       = bus.PC[ADDR_BITS-1:4+IDX_W];
  assign pc_unused = ^{bus.PC[31:ADDR_BITS], bus.PC[1:0]};
  assign hit       = valid_q[index] && (tag_q[index] == tag);

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;
`endif

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    miss_addr_d = miss_addr_q;
    fill_data_d = fill_data_q;
    mem_read_d  = mem_read_q;
    case (state_q)
      S_IDLE: begin
        if (!hit) begin
          miss_addr_d = {tag, index};
          mem_read_d  = 1'b1;
          state_d     = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        if (!bus.MEM_BUSYWAIT) begin
          fill_data_d = bus.MEM_READDATA;
          mem_read_d  = 1'b0;
          state_d     = S_UPDATE;
        end
      end
      S_UPDATE: begin
        // The fill uses only the latched miss address, never the live PC.
        valid_d[miss_addr_q[IDX_W-1:0]] = 1'b1;
        tag_d[miss_addr_q[IDX_W-1:0]]   = miss_addr_q[BLK_W-1:IDX_W];
        data_d[miss_addr_q[IDX_W-1:0]]  = fill_data_q;
        state_d                         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_IDLE && hit && hit_count_q != 16'hFFFF)
      hit_count_d = hit_count_q + 16'd1;
    if (state_q == S_IDLE && !hit && miss_count_q != 16'hFFFF)
      miss_count_d = miss_count_q + 16'd1;
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      fill_data_q <= '0;
      mem_read_q  <= 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
`ifdef ICACHE_STATS_EN
      hit_count_q  <= '0;
      miss_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      miss_addr_q <= miss_addr_d;
      fill_data_q <= fill_data_d;
      mem_read_q  <= mem_read_d;
`ifdef ICACHE_STATS_EN
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
`endif
    end
  end

  // Stall is combinational so a miss freezes the CPU in its detect cycle.
  assign bus.BUSYWAIT    = !RESET && ((state_q != S_IDLE) || !hit);
  assign bus.MEM_READ    = mem_read_q;
  assign bus.MEM_ADDRESS = miss_addr_q;
  assign bus.INSTRUCTION = data_q[index][{offset, 5'b00000} +: 32];

`ifdef ICACHE_STATS_EN
  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller: vector table plus scoreboard,
// a behavioural instruction memory, and hand sequences for reset/PC-glitch corners.
module tb_icache_controller;

  logic CLK;
  logic RESET;

  icache_controller_if #(.ADDR_BITS(10)) bus ();

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  icache_controller #(.NUM_BLOCKS(8), .ADDR_BITS(10)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT  (hit_count),
    .MISS_COUNT (miss_count)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    bit          miss;
    logic [5:0]  addr;
    int          stall;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic [31:0] glitch_pc;
    bit          miss;
    int          blk;
    int          w;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];
  int   n_checks;
  int   n_fail;
  int   cur_lat;
  int   rd_cnt;
  int   exp_misses;
  int   exp_hits;
  bit   hit_sample;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_of(input int blk, input int w);
    if (blk == 0) begin
      case (w)
        0:       return 32'h00010005;
        1:       return 32'h01070001;
        2:       return 32'h00020007;
        default: return 32'h01060002;
      endcase
    end
    return 32'hA5000000 + 32'(blk << 8) + 32'(w);
  endfunction

  function automatic logic [127:0] block_of(input logic [5:0] blk);
    logic [127:0] b;
    b = '0;
    for (int w = 0; w < 4; w++) b[32*w +: 32] = word_of(int'(blk), w);
    return b;
  endfunction

  // Slow memory: holds MEM_BUSYWAIT for cur_lat-1 read cycles, then presents data for one cycle.
  always @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_cnt           = 0;
      bus.MEM_BUSYWAIT = 1'b1;
    end else if (bus.MEM_READ === 1'b1) begin
      if (rd_cnt >= cur_lat - 1) begin
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = block_of(bus.MEM_ADDRESS);
      end else begin
        bus.MEM_BUSYWAIT = 1'b1;
      end
      rd_cnt++;
    end else begin
      rd_cnt           = 0;
      bus.MEM_BUSYWAIT = 1'b1;
    end
  end

  // Hit-count reference: a clock edge with the CPU not stalled is an IDLE hit.
  always @(negedge CLK or posedge RESET) begin
    if (RESET) hit_sample = 1'b0;
    else       hit_sample = (bus.BUSYWAIT === 1'b0);
  end

  always @(posedge CLK or posedge RESET) begin
    if (RESET) exp_hits = 0;
    else if (hit_sample && exp_hits != 65535) exp_hits++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushExp(input vec_t v);
    exp_t e;
    e.instr = word_of(v.blk, v.w);
    e.miss  = v.miss;
    e.addr  = 6'(v.blk);
    e.stall = v.miss ? v.lat + 2 : 0;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge CLK);
    #1;
    cur_lat = v.lat;
    bus.PC  = v.pc;
    pushExp(v);
  endtask

  task automatic waitResult(input logic [31:0] pc, input logic [31:0] glitch_pc);
    exp_t        e;
    int          stalls   = 0;
    int          addr_bad = 0;
    bit          saw_read = 0;
    bit          done     = 0;
    bit          glitched = 0;
    logic [31:0] orig_pc;
    orig_pc = bus.PC;
    e       = sb[0];
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (bus.BUSYWAIT === 1'b0) begin
        done = 1;
      end else begin
        stalls++;
        if (glitched) bus.PC = orig_pc;
        if (bus.MEM_READ === 1'b1) begin
          saw_read = 1;
          if (bus.MEM_ADDRESS !== e.addr) addr_bad++;
          if (glitch_pc != 0 && !glitched) begin
            bus.PC   = glitch_pc;
            glitched = 1;
          end
        end
      end
    end
    e = sb.pop_front();
    checkOutput($sformatf("pc=%0h completes", pc), 32'(done), 32'd1);
    checkOutput($sformatf("pc=%0h instruction", pc), bus.INSTRUCTION, e.instr);
    checkOutput($sformatf("pc=%0h stall cycles", pc), 32'(stalls), 32'(e.stall));
    checkOutput($sformatf("pc=%0h mem_read seen", pc), 32'(saw_read), 32'(e.miss));
    checkOutput($sformatf("pc=%0h mem_address errors", pc), 32'(addr_bad), 32'd0);
    if (e.miss) exp_misses++;
  endtask

  initial begin
    vec_t v;
    n_checks   = 0;
    n_fail     = 0;
    exp_misses = 0;
    cur_lat    = 5;
    RESET      = 1'b1;
    bus.PC     = 32'h0;

    //         pc         lat glitch      miss blk  w
    vecs[0]  = '{32'h004, 5, 32'h0,   1'b0, 0,   1};
    vecs[1]  = '{32'h008, 5, 32'h0,   1'b0, 0,   2};
    vecs[2]  = '{32'h00C, 5, 32'h0,   1'b0, 0,   3};
    vecs[3]  = '{32'h010, 4, 32'h0,   1'b1, 1,   0};
    vecs[4]  = '{32'h080, 5, 32'h0,   1'b1, 8,   0};
    vecs[5]  = '{32'h000, 5, 32'h0,   1'b1, 0,   0};
    vecs[6]  = '{32'h404, 5, 32'h0,   1'b0, 0,   1};
    vecs[7]  = '{32'h01B, 5, 32'h0,   1'b0, 1,   2};
    vecs[8]  = '{32'h084, 1, 32'h0,   1'b1, 8,   1};
    vecs[9]  = '{32'h3FC, 2, 32'h0,   1'b1, 63,  3};
    vecs[10] = '{32'h3F0, 2, 32'h0,   1'b0, 63,  0};
    vecs[11] = '{32'h400, 3, 32'h0,   1'b1, 0,   0};
    vecs[12] = '{32'h020, 5, 32'h2A0, 1'b1, 2,   0};
    vecs[13] = '{32'h024, 5, 32'h0,   1'b0, 2,   1};
    vecs[14] = '{32'h000, 5, 32'h0,   1'b0, 0,   0};

    repeat (2) @(negedge CLK);
    checkOutput("reset BUSYWAIT", 32'(bus.BUSYWAIT), 32'd0);
    checkOutput("reset MEM_READ", 32'(bus.MEM_READ), 32'd0);
    checkOutput("reset INSTRUCTION", bus.INSTRUCTION, 32'd0);
    checkOutput("reset MEM_ADDRESS", 32'(bus.MEM_ADDRESS), 32'd0);
`ifdef ICACHE_STATS_EN
    checkOutput("reset HIT_COUNT", 32'(hit_count), 32'd0);
    checkOutput("reset MISS_COUNT", 32'(miss_count), 32'd0);
`endif

    // Cold miss straight out of reset with PC=0.
    pushExp('{32'h000, 5, 32'h0, 1'b1, 0, 0});
    @(posedge CLK);
    #1 RESET = 1'b0;
    waitResult(32'h000, 32'h0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      waitResult(vecs[i].pc, vecs[i].glitch_pc);
`ifdef ICACHE_STATS_EN
      if (i == 5) begin
        checkOutput("MISS_COUNT after conflicts", 32'(miss_count), 32'(exp_misses));
        checkOutput("HIT_COUNT after conflicts", 32'(hit_count), 32'(exp_hits));
      end
`endif
    end

    // Reset pulse in the middle of a refill of line 3.
    v = '{32'h030, 5, 32'h0, 1'b1, 3, 0};
    applyStimulus(v);
    for (int c = 0; c < 20 && bus.MEM_READ !== 1'b1; c++) @(negedge CLK);
    checkOutput("refill started before reset", 32'(bus.MEM_READ), 32'd1);
    #1 RESET = 1'b1;
    #1;
    checkOutput("mid-refill reset MEM_READ", 32'(bus.MEM_READ), 32'd0);
    checkOutput("mid-refill reset BUSYWAIT", 32'(bus.BUSYWAIT), 32'd0);
    checkOutput("mid-refill reset INSTRUCTION", bus.INSTRUCTION, 32'd0);
    void'(sb.pop_front());
    bus.PC  = 32'h004;
    cur_lat = 5;
    pushExp('{32'h004, 5, 32'h0, 1'b1, 0, 1});
    sb[sb.size()-1].stall = 6;
    #1 RESET = 1'b0;
    waitResult(32'h004, 32'h0);

    // Line 1 was valid before the reset, so it must refill now.
    v = '{32'h010, 2, 32'h0, 1'b1, 1, 0};
    applyStimulus(v);
    waitResult(v.pc, 32'h0);

`ifdef ICACHE_STATS_EN
    repeat (70000) @(posedge CLK);
    @(negedge CLK);
    checkOutput("HIT_COUNT saturation", 32'(hit_count), 32'h0000FFFF);
    checkOutput("HIT_COUNT model saturation", 32'(hit_count), 32'(exp_hits));
    #1 RESET = 1'b1;
    #2;
    checkOutput("stats reset HIT_COUNT", 32'(hit_count), 32'd0);
    checkOutput("stats reset MISS_COUNT", 32'(miss_count), 32'd0);
    #1 RESET = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
